llc_set_scheduler: RTL and testbench
====================================

LLC_SET_SCHEDULER -- requirements
Module: llc_set_scheduler

Interface
REQ-001 Parameter SET_BITS, default `LLC_SET_BITS, width of a set index.
REQ-002 Parameter TABLE_SIZE, default 5, number of set-table entries; the pointer width is 3 bits.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  2  per-requester request valid; bit 0 is the CPU path, bit 1 is the DMA path.
REQ-006 req_set0 / req_set1  in  SET_BITS  set index of requester 0 / 1.
REQ-007 req_ready  out  2  one-hot accept pulse for the granted requester.
REQ-008 tbl_check  out  1  drives check_set_table; tbl_set  out  SET_BITS  drives set_next.
REQ-009 tbl_hit  in  1  from is_set_in_table; tbl_ptr  in  3  from set_table_pointer.
REQ-010 tbl_add  out  1  drives add_set_to_table; tbl_remove  out  1  and tbl_remove_ptr  out  3  drive the remove port.
REQ-011 issue_valid  out  1, issue_ready  in  1, issue_set  out  SET_BITS, issue_src  out  1, issue_ptr  out  3: handshake to the LLC pipeline.
REQ-012 done_valid  in  1, done_ptr  in  3: completion of the transaction that holds entry done_ptr.
REQ-013 occupancy  out  3  count of live entries; full  out  1; err_underflow  out  1  sticky flag.

Function
REQ-014 The FSM SHALL have four states: IDLE, CHECK, WAIT and ISSUE.
REQ-015 IDLE: if any req_valid is set and occupancy<TABLE_SIZE, the block SHALL grant one requester, pulse its req_ready for one cycle, latch its set and source, and go to CHECK. Otherwise it SHALL stay in IDLE with req_ready=0.
REQ-016 CHECK: the block SHALL assert tbl_check=1 with tbl_set equal to the latched set and sample tbl_hit in the same cycle.
  - Hit: go to WAIT.
  - Miss: pulse tbl_add for one cycle, latch issue_ptr=tbl_ptr, and go to ISSUE.
REQ-017 WAIT: tbl_check SHALL be 0. When done_valid=1 the block SHALL go to CHECK on the next cycle.
REQ-018 ISSUE: issue_valid SHALL be 1, with issue_set, issue_src and issue_ptr held stable, until issue_ready=1. The block SHALL then return to IDLE.
REQ-019 Grant-to-issue_valid latency SHALL be exactly 2 cycles on a miss.
REQ-020 When done_valid=1, tbl_remove SHALL equal 1 and tbl_remove_ptr SHALL equal done_ptr in the same cycle, combinationally, in any state.
REQ-021 Occupancy rules:
  - It SHALL increment on tbl_add and decrement on a valid done.
  - If both occur in the same cycle, it SHALL stay unchanged.
  - full SHALL be 1 exactly when occupancy==TABLE_SIZE.
REQ-022 A done_valid while occupancy==0 SHALL be ignored for counting: no wrap below 0, tbl_remove is still driven, and err_underflow is set until reset.
REQ-023 A request that arrives while full SHALL wait in IDLE, unaccepted. It SHALL be granted in the cycle after occupancy drops below TABLE_SIZE.
REQ-024 req_valid deassertion while not granted SHALL have no effect; accepted requests are never dropped.

Reset
REQ-025 On rst=0 the block SHALL enter IDLE and set occupancy=0, the round-robin pointer=0 and err_underflow=0.
REQ-026 During reset all outputs SHALL be 0 (req_ready, tbl_*, issue_*, full).
REQ-027 Reset mid-operation SHALL abandon any latched request. The external set table is reset on the same signal.

Configuration
REQ-028 The arbitration policy SHALL depend on the macro LLC_SCHED_ROUND_ROBIN_EN.
  - Defined: arbitration SHALL be round-robin. The pointer moves to the other requester after each grant, and the pointer's requester wins a tie.
  - Undefined: requester 0 SHALL always win a tie, and the pointer logic SHALL be absent.

Verification
REQ-029 Single miss: req_valid=01, set=0x12, tbl_hit=0, tbl_ptr=3 -> tbl_add pulse on cycle 1, issue_valid on cycle 2 with issue_ptr=3, occupancy=1.
REQ-030 Conflict: tbl_hit=1 in CHECK -> WAIT with no tbl_add; done_valid with done_ptr=3 -> tbl_remove_ptr=3, then re-CHECK and issue after the miss.
REQ-031 Full: five misses with no done -> full=1 and the sixth request gets no req_ready; one done -> the sixth request is granted the next cycle.
REQ-032 Tie: req_valid=11 for two grants -> with LLC_SCHED_ROUND_ROBIN_EN grants are 0 then 1; without it, 0 then 0.
REQ-033 Underflow and simultaneous events: done with occupancy 0 -> err_underflow=1 and occupancy stays 0; add and done in the same cycle -> occupancy unchanged.
REQ-034 Reset in ISSUE: rst=0 -> issue_valid=0, occupancy=0 and IDLE immediately.

Source files
------------

// File: rtl/llc_set_scheduler.sv
// llc_set_scheduler: serialises CPU/DMA set requests through an external set table into the LLC pipeline.
// Define LLC_SCHED_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 wins every tie.
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 8
`endif
module llc_set_scheduler #(
    parameter int SET_BITS   = `LLC_SET_BITS,
    parameter int TABLE_SIZE = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    input  logic [SET_BITS-1:0] req_set0,
    input  logic [SET_BITS-1:0] req_set1,
    output logic [1:0]          req_ready,
    output logic                tbl_check,
    output logic [SET_BITS-1:0] tbl_set,
    input  logic                tbl_hit,
    input  logic [2:0]          tbl_ptr,
    output logic                tbl_add,
    output logic                tbl_remove,
    output logic [2:0]          tbl_remove_ptr,
    output logic                issue_valid,
    input  logic                issue_ready,
    output logic [SET_BITS-1:0] issue_set,
    output logic                issue_src,
    output logic [2:0]          issue_ptr,
    input  logic                done_valid,
    input  logic [2:0]          done_ptr,
    output logic [2:0]          occupancy,
    output logic                full,
    output logic                err_underflow
);
    typedef enum logic [1:0] {IDLE, CHECK, WAIT, ISSUE} state_t;
    localparam logic [2:0] TS = 3'(TABLE_SIZE);
    state_t state_q, state_d;
    logic [SET_BITS-1:0] set_q, set_d;
    logic src_q, src_d;
    logic [2:0] ptr_q, ptr_d, occ_q, occ_d;
    logic uf_q, uf_d;
    logic grant, win, dec;
`ifdef LLC_SCHED_ROUND_ROBIN_EN
    logic rr_q, rr_d;
    assign win  = (&req_valid) ? rr_q : ~req_valid[0];
    assign rr_d = grant ? ~win : rr_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) rr_q <= 1'b0;
        else      rr_q <= rr_d;
`else
    assign win = ~req_valid[0];
`endif
    assign grant = state_q == IDLE && |req_valid && occ_q < TS;
    // Input-driven outputs are gated so they read 0 while reset is held.
    assign req_ready      = {2{grant & rst}} & (win ? 2'b10 : 2'b01);
    assign tbl_remove     = done_valid & rst;
    assign tbl_remove_ptr = {3{rst}} & done_ptr;
    assign tbl_set        = set_q;
    assign issue_set      = set_q;
    assign issue_src      = src_q;
    assign issue_ptr      = ptr_q;
    assign occupancy      = occ_q;
    assign full           = occ_q == TS;
    assign err_underflow  = uf_q;
    assign dec            = done_valid && occ_q != 3'd0;
    assign occ_d          = occ_q + {2'b0, tbl_add} - {2'b0, dec};
    assign uf_d           = uf_q | (done_valid && occ_q == 3'd0);
    always_comb begin
        state_d     = state_q;
        set_d       = set_q;
        src_d       = src_q;
        ptr_d       = ptr_q;
        tbl_check   = 1'b0;
        tbl_add     = 1'b0;
        issue_valid = 1'b0;
        case (state_q)
            IDLE: if (grant) begin
                set_d   = win ? req_set1 : req_set0;
                src_d   = win;
                state_d = CHECK;
            end
            CHECK: begin
                tbl_check = 1'b1;
                if (tbl_hit) state_d = WAIT;
                else begin
                    tbl_add = 1'b1;
                    ptr_d   = tbl_ptr;
                    state_d = ISSUE;
                end
            end
            WAIT: if (done_valid) state_d = CHECK;
            ISSUE: begin
                issue_valid = 1'b1;
                if (issue_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            set_q   <= '0;
            src_q   <= 1'b0;
            ptr_q   <= 3'd0;
            occ_q   <= 3'd0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            occ_q   <= occ_d;
            uf_q    <= uf_d;
        end
endmodule

// File: tb/tb_llc_set_scheduler.sv
// tb_llc_set_scheduler: random traffic against a transaction-level model of the scheduler and its set table.
module tb_llc_set_scheduler;
    localparam int SB = 8;
    logic clk = 0, rst = 0;
    logic [1:0] req_valid = 0, req_ready;
    logic [SB-1:0] req_set0 = 0, req_set1 = 0, tbl_set, issue_set;
    logic tbl_check, tbl_hit = 0, tbl_add, tbl_remove, issue_valid, issue_ready = 0, issue_src;
    logic [2:0] tbl_ptr = 0, tbl_remove_ptr, issue_ptr, done_ptr = 0, occupancy;
    logic done_valid = 0, full, err_underflow;

    llc_set_scheduler #(.SET_BITS(SB), .TABLE_SIZE(5)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_set0(req_set0), .req_set1(req_set1),
        .req_ready(req_ready), .tbl_check(tbl_check), .tbl_set(tbl_set), .tbl_hit(tbl_hit),
        .tbl_ptr(tbl_ptr), .tbl_add(tbl_add), .tbl_remove(tbl_remove), .tbl_remove_ptr(tbl_remove_ptr),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_set(issue_set),
        .issue_src(issue_src), .issue_ptr(issue_ptr), .done_valid(done_valid), .done_ptr(done_ptr),
        .occupancy(occupancy), .full(full), .err_underflow(err_underflow));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction-level model: one request in flight, a set table of five slots, a live-entry count.
    bit busy, waiting, issuing, uf, rr;
    int cyc, check_cyc, occ;
    logic [SB-1:0] p_set;
    bit p_src;
    logic [2:0] p_ptr;
    bit tv[5];
    logic [SB-1:0] ts[5];
    int req_pct, done_pct, ready_pct;
    logic [SB-1:0] set_mask;
    bit both;

    task automatic model_reset();
        busy = 0; waiting = 0; issuing = 0; uf = 0; rr = 0; occ = 0;
        for (int k = 0; k < 5; k++) tv[k] = 0;
    endtask

    task automatic step();
        bit g, w, chk_now, add, hit, dec;
        int start, j;
        @(negedge clk);
        req_valid = ($urandom_range(99) < req_pct) ? (both ? 2'b11 : 2'($urandom_range(1, 3))) : 2'b00;
        req_set0 = SB'($urandom) & set_mask;
        req_set1 = SB'($urandom) & set_mask;
        issue_ready = $urandom_range(99) < ready_pct;
        done_valid = 0;
        done_ptr = 3'($urandom_range(7));
        if ($urandom_range(99) < done_pct) begin
            if (occ == 0) done_valid = 1;
            else begin
                start = $urandom_range(4);
                for (int k = 0; k < 5; k++) begin
                    j = (start + k) % 5;
                    if (tv[j] && !done_valid) begin done_valid = 1; done_ptr = 3'(j); end
                end
            end
        end
        #1;
        hit = 0;
        tbl_ptr = 0;
        for (int k = 4; k >= 0; k--) begin
            if (tv[k] && ts[k] == tbl_set) hit = 1;
            if (!tv[k]) tbl_ptr = 3'(k);
        end
        tbl_hit = hit;
        #1;
        g = !busy && req_valid != 0 && occ < 5;
`ifdef LLC_SCHED_ROUND_ROBIN_EN
        w = (req_valid == 2'b11) ? rr : !req_valid[0];
`else
        w = !req_valid[0];
`endif
        chk_now = busy && !waiting && !issuing && cyc == check_cyc;
        add = chk_now && !tbl_hit;
        chk("req_ready", 32'(req_ready), g ? (w ? 2 : 1) : 0);
        chk("tbl_check", 32'(tbl_check), 32'(chk_now));
        if (chk_now) chk("tbl_set", 32'(tbl_set), 32'(p_set));
        chk("tbl_add", 32'(tbl_add), 32'(add));
        chk("issue_valid", 32'(issue_valid), 32'(issuing));
        if (issuing) begin
            chk("issue_set", 32'(issue_set), 32'(p_set));
            chk("issue_src", 32'(issue_src), 32'(p_src));
            chk("issue_ptr", 32'(issue_ptr), 32'(p_ptr));
        end
        chk("tbl_remove", 32'(tbl_remove), 32'(done_valid));
        if (done_valid) chk("tbl_remove_ptr", 32'(tbl_remove_ptr), 32'(done_ptr));
        chk("occupancy", 32'(occupancy), occ);
        chk("full", 32'(full), 32'(occ == 5));
        chk("err_underflow", 32'(err_underflow), 32'(uf));
        if (done_valid && done_ptr < 5) tv[done_ptr] = 0;
        if (add) begin tv[tbl_ptr] = 1; ts[tbl_ptr] = p_set; end
        dec = done_valid && occ > 0;
        if (done_valid && occ == 0) uf = 1;
        occ = occ + int'(add) - int'(dec);
        if (g) begin
            busy = 1; p_set = w ? req_set1 : req_set0; p_src = w; check_cyc = cyc + 1; rr = !w;
        end else if (chk_now) begin
            if (tbl_hit) waiting = 1;
            else begin issuing = 1; p_ptr = tbl_ptr; end
        end else if (waiting && done_valid) begin
            waiting = 0; check_cyc = cyc + 1;
        end else if (issuing && issue_ready) begin
            busy = 0; issuing = 0;
        end
        cyc++;
    endtask

    task automatic phase(input int n, input int rq, input bit bt, input logic [SB-1:0] m, input int dn, input int rd);
        req_pct = rq; both = bt; set_mask = m; done_pct = dn; ready_pct = rd;
        repeat (n) step();
    endtask

    initial begin
        int n;
        model_reset();
        cyc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 2'b11;
        done_valid = 1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_tbl_remove", 32'(tbl_remove), 0);
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_issue_valid", 32'(issue_valid), 0);
        chk("rst_full", 32'(full), 0);
        req_valid = 0;
        done_valid = 0;
        rst = 1;
        phase(3, 0, 0, 8'hff, 100, 100);
        phase(60, 100, 1, 8'hff, 0, 100);
        phase(600, 70, 0, 8'h07, 25, 60);
        n = 0;
        while (!issuing && n < 200) begin step(); n++; end
        chk("reach_issue", 32'(issuing), 1);
        @(negedge clk);
        #1;
        chk("pre_rst_issue_valid", 32'(issue_valid), 1);
        rst = 0;
        req_valid = 2'b11;
        done_valid = 1;
        #1;
        chk("mid_rst_issue_valid", 32'(issue_valid), 0);
        chk("mid_rst_occupancy", 32'(occupancy), 0);
        chk("mid_rst_req_ready", 32'(req_ready), 0);
        chk("mid_rst_tbl_remove", 32'(tbl_remove), 0);
        chk("mid_rst_underflow", 32'(err_underflow), 0);
        model_reset();
        @(posedge clk);
        #1;
        req_valid = 0;
        done_valid = 0;
        rst = 1;
        phase(300, 70, 0, 8'h07, 25, 60);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
